// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe_top.
// master = operand-fetch/writeback side, slave = the ALU pipeline.
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] R2;
    logic [WIDTH-1:0] R3;
    logic [2:0]       ALUop;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] R0;
    logic             zero;
    logic             carry;
    logic             overflow;

    modport master (
        output in_valid, R2, R3, ALUop, out_ready,
        input  in_ready, out_valid, R0, zero, carry, overflow
    );

    modport slave (
        input  in_valid, R2, R3, ALUop, out_ready,
        output in_ready, out_valid, R0, zero, carry, overflow
    );
endinterface

// File: rtl/alu_pipe_top.sv
// Two-stage valid/ready pipelined ALU: stage 1 registers operands, stage 2 result + flags.
// Optional sticky overflow/carry accumulation enabled by defining ALU_STICKY_FLAGS_EN.
module alu_pipe_top #(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_pipe_if.slave  bus
`ifdef ALU_STICKY_FLAGS_EN
    ,
    input  logic       sticky_clr,
    output logic       sticky_ovf,
    output logic       sticky_carry
`endif
);
    localparam int unsigned SHW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OpAnd = 3'b000,
        OpOr  = 3'b001,
        OpAdd = 3'b010,
        OpSub = 3'b011,
        OpXor = 3'b100,
        OpNor = 3'b101,
        OpSlt = 3'b110,
        OpSll = 3'b111
    } alu_op_e;

    // Stage 1 state
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    alu_op_e          s1_op_q;

    // Stage 2 state (drives the outputs directly)
    logic             s2_valid_q;
    logic [WIDTH-1:0] r0_q;
    logic             zero_q;
    logic             carry_q;
    logic             ovf_q;

    // Handshake / advance
    logic s2_adv;
    logic s1_adv;
    logic in_hs;

    always_comb begin
        s2_adv = !s2_valid_q || bus.out_ready;
        s1_adv = !s1_valid_q || s2_adv;
        in_hs  = bus.in_valid && s1_adv;
    end

    // ALU datapath on stage-1 contents
    logic             use_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;
    logic             add_ovf;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic             alu_zero;

    always_comb begin
        use_sub   = (s1_op_q == OpSub) || (s1_op_q == OpSlt);
        b_eff     = use_sub ? ~s1_b_q : s1_b_q;
        sum_ext   = {1'b0, s1_a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, use_sub};
        // Signed overflow: operand signs agree but result sign differs.
        add_ovf   = (s1_a_q[WIDTH-1] == b_eff[WIDTH-1]) &&
                    (sum_ext[WIDTH-1] != s1_a_q[WIDTH-1]);
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        unique case (s1_op_q)
            OpAnd: alu_res = s1_a_q & s1_b_q;
            OpOr:  alu_res = s1_a_q | s1_b_q;
            OpAdd, OpSub: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
                alu_ovf   = add_ovf;
            end
            OpXor: alu_res = s1_a_q ^ s1_b_q;
            OpNor: alu_res = ~(s1_a_q | s1_b_q);
            OpSlt: alu_res = {{(WIDTH-1){1'b0}}, sum_ext[WIDTH-1] ^ add_ovf};
            OpSll: alu_res = s1_a_q << s1_b_q[SHW-1:0];
        endcase
        alu_zero = (alu_res == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            r0_q       <= '0;
            zero_q     <= 1'b1;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (in_hs) begin
                s1_valid_q <= 1'b1;
                s1_a_q     <= bus.R2;
                s1_b_q     <= bus.R3;
                s1_op_q    <= alu_op_e'(bus.ALUop);
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                // Result registers only take real bundles so R0/flags keep the last result.
                if (s1_valid_q) begin
                    r0_q    <= alu_res;
                    zero_q  <= alu_zero;
                    carry_q <= alu_carry;
                    ovf_q   <= alu_ovf;
                end
            end
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid_q;
    assign bus.R0        = r0_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;

`ifdef ALU_STICKY_FLAGS_EN
    logic sticky_ovf_q;
    logic sticky_carry_q;

    // Clear wins over a same-cycle handshake; that handshake's flags are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_ovf_q   <= 1'b0;
            sticky_carry_q <= 1'b0;
        end else if (sticky_clr) begin
            sticky_ovf_q   <= 1'b0;
            sticky_carry_q <= 1'b0;
        end else if (s2_valid_q && bus.out_ready) begin
            sticky_ovf_q   <= sticky_ovf_q | ovf_q;
            sticky_carry_q <= sticky_carry_q | carry_q;
        end
    end

    assign sticky_ovf   = sticky_ovf_q;
    assign sticky_carry = sticky_carry_q;
`endif
endmodule
